hvsync_generator: RTL and testbench

HVSYNC_GENERATOR -- requirements
Module: hvsync_generator

---
 rtl/hvsync_generator_pkg.sv | 30 +++
 rtl/hvsync_generator_sync_axis_counter.sv | 81 ++++++++
 rtl/hvsync_generator.sv | 103 ++++++++++
 tb/tb_hvsync_generator.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/hvsync_generator_pkg.sv
// Shared SVGA 800x600@72 (50 MHz pixel clock) timing constants and helpers
// for the sync generator and every consumer of its pixel coordinates.
package hvsync_generator_pkg;

  localparam int CNTR_WIDTH_H_DEFAULT = 11;
  localparam int CNTR_WIDTH_V_DEFAULT = 10;

  localparam int SVGA_H_VISIBLE = 800;
  localparam int SVGA_H_FP      = 56;
  localparam int SVGA_H_SYNC    = 120;
  localparam int SVGA_H_BP      = 64;

  localparam int SVGA_V_VISIBLE = 600;
  localparam int SVGA_V_FP      = 37;
  localparam int SVGA_V_SYNC    = 6;
  localparam int SVGA_V_BP      = 23;

  localparam logic SVGA_HS_POL = 1'b1;
  localparam logic SVGA_VS_POL = 1'b1;

  // True when a counter of the given width can hold every value 0..total-1.
  function automatic bit fits_width(input int total, input int width);
    if (width >= 31) begin
      return 1'b1;
    end else begin
      return total <= (32'sd1 <<< width);
    end
  endfunction

endpackage

// File: rtl/hvsync_generator_sync_axis_counter.sv
// One timing axis: wrapping position counter plus registered sync decode,
// with the sync level computed from the next count so it lines up with it.
module sync_axis_counter
  import hvsync_generator_pkg::*;
#(
  parameter int   WIDTH   = CNTR_WIDTH_H_DEFAULT,
  parameter int   VISIBLE = SVGA_H_VISIBLE,
  parameter int   FP      = SVGA_H_FP,
  parameter int   SYNC    = SVGA_H_SYNC,
  parameter int   BP      = SVGA_H_BP,
  parameter logic POL     = SVGA_HS_POL
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic             advance,
  output logic [WIDTH-1:0] count,
  output logic             at_last,
  output logic             visible_next,
  output logic             sync
);

  localparam int TOTAL = VISIBLE + FP + SYNC + BP;
  localparam logic [WIDTH-1:0] LAST_C       = WIDTH'(TOTAL - 1);
  localparam logic [WIDTH-1:0] VISIBLE_C    = WIDTH'(VISIBLE);
  localparam logic [WIDTH-1:0] SYNC_FIRST_C = WIDTH'(VISIBLE + FP);
  localparam logic [WIDTH-1:0] SYNC_LAST_C  = WIDTH'(VISIBLE + FP + SYNC - 1);

  if (!fits_width(TOTAL, WIDTH)) begin : g_width_check
    $error("sync_axis_counter: timing total %0d does not fit in %0d bits", TOTAL, WIDTH);
  end

  logic [WIDTH-1:0] count_r;
  logic [WIDTH-1:0] count_next_s;
  logic             sync_r;
  logic             sync_next_s;
  logic             at_last_s;

  assign at_last_s = (count_r == LAST_C);

  // Next position: step or wrap when advancing, otherwise hold.
  always_comb begin
    count_next_s = count_r;
    if (advance) begin
      if (at_last_s) begin
        count_next_s = '0;
      end else begin
        count_next_s = count_r + WIDTH'(1);
      end
    end else begin
      count_next_s = count_r;
    end
  end

  // Sync window decode on the upcoming position.
  always_comb begin
    sync_next_s = ~POL;
    if ((count_next_s >= SYNC_FIRST_C) && (count_next_s <= SYNC_LAST_C)) begin
      sync_next_s = POL;
    end else begin
      sync_next_s = ~POL;
    end
  end

  // Position and sync registers; reset parks on the last position so the
  // first enabled edge lands on 0.
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      count_r <= LAST_C;
      sync_r  <= ~POL;
    end else begin
      count_r <= count_next_s;
      sync_r  <= sync_next_s;
    end
  end

  assign count        = count_r;
  assign sync         = sync_r;
  assign at_last      = at_last_s;
  assign visible_next = (count_next_s < VISIBLE_C);

endmodule

// File: rtl/hvsync_generator.sv
// VGA horizontal/vertical sync generator with frame start pulse and counter.
// All outputs except VGA_SYNC_N are registered and aligned with CounterX/Y.
module hvsync_generator
  import hvsync_generator_pkg::*;
#(
  parameter int   CNTR_WIDTH_H = CNTR_WIDTH_H_DEFAULT,
  parameter int   CNTR_WIDTH_V = CNTR_WIDTH_V_DEFAULT,
  parameter int   H_VISIBLE    = SVGA_H_VISIBLE,
  parameter int   H_FP         = SVGA_H_FP,
  parameter int   H_SYNC       = SVGA_H_SYNC,
  parameter int   H_BP         = SVGA_H_BP,
  parameter int   V_VISIBLE    = SVGA_V_VISIBLE,
  parameter int   V_FP         = SVGA_V_FP,
  parameter int   V_SYNC       = SVGA_V_SYNC,
  parameter int   V_BP         = SVGA_V_BP,
  parameter logic HS_POL       = SVGA_HS_POL,
  parameter logic VS_POL       = SVGA_VS_POL
) (
  input  logic                    CLK,
  input  logic                    RST_N,
  input  logic                    PixelEn,
  output logic [CNTR_WIDTH_H-1:0] CounterX,
  output logic [CNTR_WIDTH_V-1:0] CounterY,
  output logic                    VGA_HS,
  output logic                    VGA_VS,
  output logic                    VGA_BLANK_N,
  output logic                    VGA_SYNC_N,
  output logic                    inDisplayArea,
  output logic                    FrameStart,
  output logic [7:0]              FrameCount
);

  logic x_at_last_s;
  logic y_at_last_s;
  logic x_visible_next_s;
  logic y_visible_next_s;
  logic y_advance_s;
  logic frame_start_next_s;
  logic display_r;
  logic frame_start_r;
  logic [7:0] frame_count_r;

  assign y_advance_s        = PixelEn & x_at_last_s;
  assign frame_start_next_s = PixelEn & x_at_last_s & y_at_last_s;

  sync_axis_counter #(
    .WIDTH   (CNTR_WIDTH_H),
    .VISIBLE (H_VISIBLE),
    .FP      (H_FP),
    .SYNC    (H_SYNC),
    .BP      (H_BP),
    .POL     (HS_POL)
  ) u_h_axis (
    .CLK          (CLK),
    .RST_N        (RST_N),
    .advance      (PixelEn),
    .count        (CounterX),
    .at_last      (x_at_last_s),
    .visible_next (x_visible_next_s),
    .sync         (VGA_HS)
  );

  sync_axis_counter #(
    .WIDTH   (CNTR_WIDTH_V),
    .VISIBLE (V_VISIBLE),
    .FP      (V_FP),
    .SYNC    (V_SYNC),
    .BP      (V_BP),
    .POL     (VS_POL)
  ) u_v_axis (
    .CLK          (CLK),
    .RST_N        (RST_N),
    .advance      (y_advance_s),
    .count        (CounterY),
    .at_last      (y_at_last_s),
    .visible_next (y_visible_next_s),
    .sync         (VGA_VS)
  );

  // Display-area, frame-start pulse and frame counter registers.
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      display_r     <= 1'b0;
      frame_start_r <= 1'b0;
      frame_count_r <= 8'd0;
    end else begin
      display_r     <= x_visible_next_s & y_visible_next_s;
      frame_start_r <= frame_start_next_s;
      if (frame_start_next_s) begin
        frame_count_r <= frame_count_r + 8'd1;
      end else begin
        frame_count_r <= frame_count_r;
      end
    end
  end

  assign inDisplayArea = display_r;
  assign VGA_BLANK_N   = display_r;
  assign FrameStart    = frame_start_r;
  assign FrameCount    = frame_count_r;
  assign VGA_SYNC_N    = 1'b0;

endmodule

// File: tb/tb_hvsync_generator.sv
// Directed bench: full-size SVGA instance for line timing, plus a shrunken
// instance (18x10 frame, HS active-low) for frame-level and wrap scenarios.
module tb_hvsync_generator;

  localparam int S_HT = 18;
  localparam int S_VT = 10;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Full-size instance
  logic        rst_n_a = 1'b0, en_a = 1'b1;
  logic [10:0] x_a;
  logic [9:0]  y_a;
  logic        hs_a, vs_a, blank_a, syncn_a, disp_a, fs_a;
  logic [7:0]  fc_a;

  // Shrunken instance
  logic       rst_n_b = 1'b0, en_b = 1'b0;
  logic [4:0] x_b;
  logic [3:0] y_b;
  logic       hs_b, vs_b, blank_b, syncn_b, disp_b, fs_b;
  logic [7:0] fc_b;

  hvsync_generator u_dut_a (
    .CLK(clk), .RST_N(rst_n_a), .PixelEn(en_a), .CounterX(x_a), .CounterY(y_a),
    .VGA_HS(hs_a), .VGA_VS(vs_a), .VGA_BLANK_N(blank_a), .VGA_SYNC_N(syncn_a),
    .inDisplayArea(disp_a), .FrameStart(fs_a), .FrameCount(fc_a)
  );

  hvsync_generator #(
    .CNTR_WIDTH_H(5), .CNTR_WIDTH_V(4),
    .H_VISIBLE(10), .H_FP(2), .H_SYNC(3), .H_BP(3),
    .V_VISIBLE(5), .V_FP(1), .V_SYNC(2), .V_BP(2),
    .HS_POL(1'b0), .VS_POL(1'b1)
  ) u_dut_b (
    .CLK(clk), .RST_N(rst_n_b), .PixelEn(en_b), .CounterX(x_b), .CounterY(y_b),
    .VGA_HS(hs_b), .VGA_VS(vs_b), .VGA_BLANK_N(blank_b), .VGA_SYNC_N(syncn_b),
    .inDisplayArea(disp_b), .FrameStart(fs_b), .FrameCount(fc_b)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference model state for the shrunken instance
  int mx, my, mfc;
  bit mfs;
  int fs_seen, vs_seen, hs_seen;

  task automatic model_step(input bit rst, input bit en);
    if (!rst) begin
      mx = S_HT - 1; my = S_VT - 1; mfs = 1'b0; mfc = 0;
    end else if (en) begin
      mfs = (mx == S_HT - 1) && (my == S_VT - 1);
      if (mx == S_HT - 1) begin
        mx = 0;
        my = (my == S_VT - 1) ? 0 : my + 1;
      end else begin
        mx = mx + 1;
      end
      if (mfs) mfc = (mfc + 1) % 256;
    end else begin
      mfs = 1'b0;
    end
  endtask

  task automatic small_cycle(input bit rst, input bit en);
    rst_n_b = rst;
    en_b    = en;
    @(posedge clk);
    #1;
    model_step(rst, en);
    check("s_x",     32'(x_b),     32'(mx));
    check("s_y",     32'(y_b),     32'(my));
    check("s_hs",    32'(hs_b),    32'((mx >= 12 && mx <= 14) ? 1'b0 : 1'b1));
    check("s_vs",    32'(vs_b),    32'((my >= 6 && my <= 7) ? 1'b1 : 1'b0));
    check("s_disp",  32'(disp_b),  32'(mx < 10 && my < 5));
    check("s_blank", 32'(blank_b), 32'(mx < 10 && my < 5));
    check("s_fs",    32'(fs_b),    32'(mfs));
    check("s_fc",    32'(fc_b),    32'(mfc));
    check("s_syncn", 32'(syncn_b), 32'd0);
    if (fs_b) fs_seen++;
    if (vs_b) vs_seen++;
    if (!hs_b) hs_seen++;
  endtask

  task automatic big_cycle(input bit rst, input bit en);
    rst_n_a = rst;
    en_a    = en;
    @(posedge clk);
    #1;
  endtask

  initial begin
    int hs_cnt, hs_first;

    // ---------------- Full-size line timing ----------------
    big_cycle(1'b0, 1'b1);
    big_cycle(1'b0, 1'b1);
    check("a_rst_x", 32'(x_a), 32'd1039);
    check("a_rst_y", 32'(y_a), 32'd665);
    check("a_rst_hs", 32'(hs_a), 32'd0);
    check("a_rst_vs", 32'(vs_a), 32'd0);
    check("a_rst_blank", 32'(blank_a), 32'd0);
    check("a_rst_disp", 32'(disp_a), 32'd0);
    check("a_rst_fs", 32'(fs_a), 32'd0);
    check("a_rst_fc", 32'(fc_a), 32'd0);
    check("a_syncn", 32'(syncn_a), 32'd0);

    big_cycle(1'b1, 1'b1);
    check("a_first_x", 32'(x_a), 32'd0);
    check("a_first_y", 32'(y_a), 32'd0);
    check("a_first_fs", 32'(fs_a), 32'd1);
    check("a_first_fc", 32'(fc_a), 32'd1);
    check("a_first_blank", 32'(blank_a), 32'd1);

    hs_cnt = 0; hs_first = -1;
    for (int c = 1; c < 1040; c++) begin
      big_cycle(1'b1, 1'b1);
      check("a_line_x", 32'(x_a), 32'(c));
      check("a_line_hs", 32'(hs_a), 32'(c >= 856 && c <= 975));
      check("a_line_blank", 32'(blank_a), 32'(c < 800));
      check("a_line_fs", 32'(fs_a), 32'd0);
      if (hs_a) begin
        hs_cnt++;
        if (hs_first < 0) hs_first = c;
      end
    end
    check("a_hs_len", 32'(hs_cnt), 32'd120);
    check("a_hs_start", 32'(hs_first), 32'd856);
    big_cycle(1'b1, 1'b1);
    check("a_wrap_x", 32'(x_a), 32'd0);
    check("a_wrap_y", 32'(y_a), 32'd1);
    check("a_wrap_fc", 32'(fc_a), 32'd1);
    en_a = 1'b0;

    // ---------------- Shrunken frame scenarios ----------------
    small_cycle(1'b0, 1'b0);
    small_cycle(1'b0, 1'b1);
    check("s_rst_x", 32'(x_b), 32'd17);
    check("s_rst_y", 32'(y_b), 32'd9);

    // One full frame: FrameStart at cycle 1 and again at cycle 181
    fs_seen = 0; vs_seen = 0; hs_seen = 0;
    small_cycle(1'b1, 1'b1);
    check("s_c1_fs", 32'(fs_b), 32'd1);
    check("s_c1_fc", 32'(fc_b), 32'd1);
    for (int k = 2; k <= 180; k++) small_cycle(1'b1, 1'b1);
    check("s_frame_fs_count", 32'(fs_seen), 32'd1);
    check("s_frame_vs_cycles", 32'(vs_seen), 32'd36);
    check("s_frame_hs_cycles", 32'(hs_seen), 32'd30);
    small_cycle(1'b1, 1'b1);
    check("s_c181_fs", 32'(fs_b), 32'd1);
    check("s_c181_fc", 32'(fc_b), 32'd2);

    // Alternating enable: 180 advances over 360 edges, one FrameStart
    fs_seen = 0;
    for (int i = 0; i < 360; i++) begin
      small_cycle(1'b1, (i % 2) == 1);
      if (i == 0) check("s_hold_fs_low", 32'(fs_b), 32'd0);
      if (i == 0) check("s_hold_x", 32'(x_b), 32'd0);
    end
    check("s_toggle_fs_count", 32'(fs_seen), 32'd1);
    check("s_toggle_end_fs", 32'(fs_b), 32'd1);
    check("s_toggle_end_fc", 32'(fc_b), 32'd3);

    // Mid-frame reset at (5,3) with PixelEn low
    for (int i = 0; i < 59; i++) small_cycle(1'b1, 1'b1);
    check("s_mid_x", 32'(x_b), 32'd5);
    check("s_mid_y", 32'(y_b), 32'd3);
    small_cycle(1'b0, 1'b0);
    check("s_mrst_x", 32'(x_b), 32'd17);
    check("s_mrst_y", 32'(y_b), 32'd9);
    check("s_mrst_hs", 32'(hs_b), 32'd1);
    check("s_mrst_vs", 32'(vs_b), 32'd0);
    check("s_mrst_fc", 32'(fc_b), 32'd0);
    small_cycle(1'b0, 1'b1);

    // 256 frames: FrameCount wraps to 0 on the 256th FrameStart
    fs_seen = 0;
    small_cycle(1'b1, 1'b1);
    check("s_w_first_fc", 32'(fc_b), 32'd1);
    for (int i = 0; i < 255 * 180; i++) small_cycle(1'b1, 1'b1);
    check("s_w_fs_count", 32'(fs_seen), 32'd256);
    check("s_w_last_fs", 32'(fs_b), 32'd1);
    check("s_w_last_fc", 32'(fc_b), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
